// File: rtl/matmul_systolic_engine.sv
// Output-stationary systolic matrix multiplier: C = A*B or C += A*B for runtime N x K x M.
// Build option MATMUL_SAT_EN: clamp overflowing accumulator adds instead of wrapping.
module matmul_systolic_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
    localparam int DIM_W     = ($clog2(MAX_DIM) > 1) ? $clog2(MAX_DIM) : 1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      start_i,
    input  logic                                      mode_i,
    input  logic [DIM_W-1:0]                          n_dim_i,
    input  logic [DIM_W-1:0]                          k_dim_i,
    input  logic [DIM_W-1:0]                          m_dim_i,
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]     a_matrix_i,
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]     b_matrix_i,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0]      c_matrix_o,
    output logic [MAX_DIM*MAX_DIM-1:0]                flags_o
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int CNT_W  = $clog2(3 * MAX_DIM + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                         state_q;
    logic                           mode_q;
    logic [DIM_W-1:0]               n_q, k_q, m_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [CNT_W-1:0]               last_cnt;
    logic signed [DATA_WIDTH-1:0]   a_q [MAX_DIM][MAX_DIM];
    logic signed [DATA_WIDTH-1:0]   b_q [MAX_DIM][MAX_DIM];

    logic signed [DATA_WIDTH-1:0]   a_feed [MAX_DIM];
    logic signed [DATA_WIDTH-1:0]   b_feed [MAX_DIM];
    logic signed [DATA_WIDTH-1:0]   a_edge_p0 [MAX_DIM];
    logic signed [DATA_WIDTH-1:0]   b_edge_p0 [MAX_DIM];
    logic signed [DATA_WIDTH-1:0]   a_p1 [MAX_DIM][MAX_DIM];
    logic signed [DATA_WIDTH-1:0]   b_p1 [MAX_DIM][MAX_DIM];
    logic signed [BUS_WIDTH-1:0]    acc_q [MAX_DIM][MAX_DIM];
    logic                           flag_q [MAX_DIM][MAX_DIM];

    // Returns {overflow, next accumulator}; wraps or clamps depending on the build.
    function automatic logic [BUS_WIDTH:0] acc_add(input logic signed [BUS_WIDTH-1:0] acc,
                                                   input logic signed [PROD_W-1:0]    prod);
        logic [BUS_WIDTH:0]   sum;
        logic                 ovf;
        logic [BUS_WIDTH-1:0] res;
        sum = {acc[BUS_WIDTH-1], acc} + {{(BUS_WIDTH + 1 - PROD_W){prod[PROD_W-1]}}, prod};
        ovf = sum[BUS_WIDTH] ^ sum[BUS_WIDTH-1];
        res = sum[BUS_WIDTH-1:0];
`ifdef MATMUL_SAT_EN
        if (ovf) res = sum[BUS_WIDTH] ? {1'b1, {(BUS_WIDTH-1){1'b0}}}
                                      : {1'b0, {(BUS_WIDTH-1){1'b1}}};
`endif
        return {ovf, res};
    endfunction

    // Last RUN count is N+K+M-2 in real dimensions, i.e. n+k+m+1 in field encoding.
    assign last_cnt = CNT_W'(n_q) + CNT_W'(k_q) + CNT_W'(m_q) + CNT_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            n_q     <= '0;
            k_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int c = 0; c < MAX_DIM; c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        mode_q  <= mode_i;
                        n_q     <= n_dim_i;
                        k_q     <= k_dim_i;
                        m_q     <= m_dim_i;
                        busy_o  <= 1'b1;
                        state_q <= LOAD;
                        for (int r = 0; r < MAX_DIM; r++) begin
                            for (int c = 0; c < MAX_DIM; c++) begin
                                a_q[r][c] <= a_matrix_i[(r*MAX_DIM+c)*DATA_WIDTH +: DATA_WIDTH];
                                b_q[r][c] <= b_matrix_i[(r*MAX_DIM+c)*DATA_WIDTH +: DATA_WIDTH];
                            end
                        end
                    end
                end
                LOAD: begin
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    if (cnt_q == last_cnt) begin
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    done_o  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Skewed edge feed: row i gets A[i][t-i], column j gets B[t-j][j], zero outside the dims.
    always_comb begin
        for (int i = 0; i < MAX_DIM; i++) begin
            a_feed[i] = '0;
            b_feed[i] = '0;
            for (int k = 0; k < MAX_DIM; k++) begin
                if (int'(cnt_q) == i + k && k <= int'(k_q) && i <= int'(n_q))
                    a_feed[i] = a_q[i][k];
                if (int'(cnt_q) == i + k && k <= int'(k_q) && i <= int'(m_q))
                    b_feed[i] = b_q[k][i];
            end
        end
    end

    // Stage p0: edge registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_DIM; i++) begin
                a_edge_p0[i] <= '0;
                b_edge_p0[i] <= '0;
            end
        end else if (state_q == LOAD) begin
            for (int i = 0; i < MAX_DIM; i++) begin
                a_edge_p0[i] <= '0;
                b_edge_p0[i] <= '0;
            end
        end else if (state_q == RUN) begin
            for (int i = 0; i < MAX_DIM; i++) begin
                a_edge_p0[i] <= a_feed[i];
                b_edge_p0[i] <= b_feed[i];
            end
        end
    end

    // Stage p1: processing-element array
    for (genvar i = 0; i < MAX_DIM; i++) begin : g_row
        for (genvar j = 0; j < MAX_DIM; j++) begin : g_col
            logic signed [DATA_WIDTH-1:0] a_in, b_in;
            logic signed [PROD_W-1:0]     prod;
            logic [BUS_WIDTH:0]           add_res;

            if (j == 0) begin : g_a_edge
                assign a_in = a_edge_p0[i];
            end else begin : g_a_pass
                assign a_in = a_p1[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in = b_edge_p0[j];
            end else begin : g_b_pass
                assign b_in = b_p1[i-1][j];
            end

            assign prod    = PROD_W'(a_in) * PROD_W'(b_in);
            assign add_res = acc_add(acc_q[i][j], prod);

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    a_p1[i][j]   <= '0;
                    b_p1[i][j]   <= '0;
                    acc_q[i][j]  <= '0;
                    flag_q[i][j] <= 1'b0;
                end else if (state_q == LOAD) begin
                    a_p1[i][j] <= '0;
                    b_p1[i][j] <= '0;
                    if (!mode_q) begin
                        acc_q[i][j]  <= '0;
                        flag_q[i][j] <= 1'b0;
                    end
                end else if (state_q == RUN) begin
                    a_p1[i][j]  <= a_in;
                    b_p1[i][j]  <= b_in;
                    acc_q[i][j] <= add_res[BUS_WIDTH-1:0];
                    if (add_res[BUS_WIDTH]) flag_q[i][j] <= 1'b1;
                end
            end

            assign c_matrix_o[(i*MAX_DIM+j)*BUS_WIDTH +: BUS_WIDTH] = acc_q[i][j];
            assign flags_o[i*MAX_DIM+j] = flag_q[i][j];
        end
    end

endmodule

// File: tb/tb_matmul_systolic_engine.sv
// Directed bench for matmul_systolic_engine: default 8/32 build plus an 8/16 instance for overflow.
module tb_matmul_systolic_engine;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [1:0]   n_dim = '0, k_dim = '0, m_dim = '0;
    logic [127:0] a_bus = '0, b_bus = '0;
    logic         busy, done;
    logic [511:0] c_bus;
    logic [15:0]  flags;

    logic         start16 = 1'b0;
    logic [0:0]   n16 = '0, k16 = '0, m16 = '0;
    logic [31:0]  a16 = '0, b16 = '0;
    logic         busy16, done16;
    logic [63:0]  c16;
    logic [3:0]   flags16;

    int     errors = 0;
    int     checks = 0;
    int     am [16];
    int     bm [16];
    longint em [16];

    always #5 clk = ~clk;

    matmul_systolic_engine dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .mode_i(mode),
        .n_dim_i(n_dim), .k_dim_i(k_dim), .m_dim_i(m_dim),
        .a_matrix_i(a_bus), .b_matrix_i(b_bus),
        .busy_o(busy), .done_o(done), .c_matrix_o(c_bus), .flags_o(flags)
    );

    matmul_systolic_engine #(.DATA_WIDTH(8), .BUS_WIDTH(16)) dut16 (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start16), .mode_i(1'b0),
        .n_dim_i(n16), .k_dim_i(k16), .m_dim_i(m16),
        .a_matrix_i(a16), .b_matrix_i(b16),
        .busy_o(busy16), .done_o(done16), .c_matrix_o(c16), .flags_o(flags16)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint c_el(input int idx);
        return longint'($signed(c_bus[idx*32 +: 32]));
    endfunction

    task automatic clear_mats();
        for (int i = 0; i < 16; i++) begin
            am[i] = 0;
            bm[i] = 0;
            em[i] = 0;
        end
    endtask

    task automatic fill_all(input int av, input longint ev);
        for (int i = 0; i < 16; i++) begin
            am[i] = av;
            bm[i] = av;
            em[i] = ev;
        end
    endtask

    // Starts a run with real dimensions n,k,m and checks latency, done pulse and results.
    task automatic run_mm(input string tag, input int n, input int k, input int m,
                          input logic md, input bit poke_done);
        int cycles;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            a_bus[i*8 +: 8] = 8'(am[i]);
            b_bus[i*8 +: 8] = 8'(bm[i]);
        end
        n_dim = 2'(n - 1);
        k_dim = 2'(k - 1);
        m_dim = 2'(m - 1);
        mode  = md;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        cycles = 0;
        while (!done && cycles < 64) begin
            @(posedge clk);
            #1 cycles++;
        end
        check({tag, "_latency"}, cycles, n + k + m);
        check({tag, "_busy_at_done"}, busy, 0);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s_c%0d", tag, i), c_el(i), em[i]);
        check({tag, "_flags"}, flags, 0);
        if (poke_done) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_done_pulse"}, done, 0);
        if (poke_done) check({tag, "_start_in_done_ignored"}, busy, 0);
    endtask

    task automatic setup_2x2();
        clear_mats();
        am[0] = 1;  am[1] = 2;  am[4] = 3;  am[5] = 4;
        bm[0] = 5;  bm[1] = 6;  bm[4] = 7;  bm[5] = 8;
        am[2] = 9;  am[10] = 7; bm[15] = 5; bm[8] = -3;
        em[0] = 19; em[1] = 22; em[4] = 43; em[5] = 50;
    endtask

    initial begin
        int cycles;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_c_nonzero", longint'(c_bus != '0), 0);
        check("rst_flags", flags, 0);
        @(negedge clk) rst_ni = 1'b1;

        setup_2x2();
        run_mm("mm2x2", 2, 2, 2, 1'b0, 1'b0);

        clear_mats();
        am[0] = 1; am[4] = -2; am[8] = 3; am[1] = 100;
        bm[0] = 4; bm[1] = 5;  bm[4] = 77;
        em[0] = 4; em[1] = 5; em[4] = -8; em[5] = -10; em[8] = 12; em[9] = 15;
        run_mm("mm3x1x2", 3, 1, 2, 1'b0, 1'b0);

        fill_all(-128, 65536);
        run_mm("mm4_ovw", 4, 4, 4, 1'b0, 1'b0);
        fill_all(-128, 131072);
        run_mm("mm4_acc", 4, 4, 4, 1'b1, 1'b1);

        // Start again mid-RUN (must be ignored), then reset mid-RUN.
        @(negedge clk);
        mode = 1'b1; n_dim = 2'd3; k_dim = 2'd3; m_dim = 2'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mode = 1'b0; n_dim = 2'd0; k_dim = 2'd0; m_dim = 2'd0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("midrun_busy", busy, 1);
        check("midrun_c_nonzero", longint'(c_bus != '0), 1);
        @(posedge clk);
        #3 rst_ni = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_c_nonzero", longint'(c_bus != '0), 0);
        check("async_rst_flags", flags, 0);
        @(negedge clk) rst_ni = 1'b1;

        setup_2x2();
        run_mm("mm2x2_after_rst", 2, 2, 2, 1'b0, 1'b0);

        // Narrow accumulator build: -128*-128 summed twice overflows 16 bits.
        @(negedge clk);
        a16 = {4{8'h80}};
        b16 = {4{8'h80}};
        n16 = 1'b1; k16 = 1'b1; m16 = 1'b1;
        start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        check("ovf_busy", busy16, 1);
        cycles = 0;
        while (!done16 && cycles < 64) begin
            @(posedge clk);
            #1 cycles++;
        end
        check("ovf_latency", cycles, 6);
        check("ovf_flags", flags16, 15);
        for (int i = 0; i < 4; i++) begin
`ifdef MATMUL_SAT_EN
            check($sformatf("ovf_c%0d", i), longint'($signed(c16[i*16 +: 16])), 32767);
`else
            check($sformatf("ovf_c%0d", i), longint'($signed(c16[i*16 +: 16])), -32768);
`endif
        end
        @(posedge clk);
        #1;
        check("ovf_done_pulse", done16, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matmul_systolic_engine.md
# matmul_systolic_engine

Parametrised output-stationary systolic matrix multiplier computing C = A×B (overwrite) or C = C + A×B (accumulate) for runtime dimensions N×K by K×M, each up to MAX_DIM. It sits behind the accelerator control/register block. It accepts both operand matrices as flat row-major buses on a start handshake and returns a flat result bus with per-element overflow flags and a one-cycle done pulse. It supersedes the fixed-mode multiplier with an explicit FSM, busy/done handshake, accumulate mode, sticky overflow flags and optional saturation.

## Interface
- DATA_WIDTH, 8, signed operand element width
- BUS_WIDTH, 32, signed result element width; must be ≥ 2*DATA_WIDTH
- MAX_DIM, BUS_WIDTH/DATA_WIDTH (localparam), maximum of N, K, M
- DIM_W, max($clog2(MAX_DIM),1) (localparam), dimension field width
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  start request, sampled only in IDLE
- mode_i  in  1  0 = overwrite, 1 = accumulate into current C; sampled with start_i
- n_dim_i, k_dim_i, m_dim_i  in  DIM_W each  dimension minus 1 (0 means 1); sampled with start_i
- a_matrix_i  in  MAX_DIM*MAX_DIM*DATA_WIDTH  A, element (r,c) at [(r*MAX_DIM+c)*DATA_WIDTH +: DATA_WIDTH]
- b_matrix_i  in  same  B, same layout
- busy_o  out  1  high in LOAD and RUN
- done_o  out  1  one-cycle completion pulse
- c_matrix_o  out  MAX_DIM*MAX_DIM*BUS_WIDTH  C, element (r,c) at [(r*MAX_DIM+c)*BUS_WIDTH +: BUS_WIDTH]
- flags_o  out  MAX_DIM*MAX_DIM  sticky overflow flag, bit r*MAX_DIM+c

## Operation
- FSM has four states: IDLE, LOAD, RUN, DONE.
  - IDLE: on start_i=1, capture A, B, dims and mode into internal registers, then go to LOAD.
  - LOAD: if mode=0, clear all accumulators and flags; if mode=1, keep them. Clear the skew counter and go to RUN.
  - RUN: run for exactly N+K+M−1 cycles (N, K, M are real dimensions), then go to DONE.
  - DONE: pulse done_o, then return to IDLE.
- Array: MAX_DIM×MAX_DIM processing elements (PEs).
  - Each PE registers its a operand rightward and its b operand downward.
  - Each PE adds a*b (full 2*DATA_WIDTH signed product, sign-extended to BUS_WIDTH) into its accumulator.
- Feed, at RUN cycle t:
  - Row-edge register i loads A[i][t−i] when 0≤t−i<K and i<N, else 0.
  - Column-edge register j loads B[t−j][j] when 0≤t−j<K and j<M, else 0.
- Elements with r≥N or c≥M see only zero operands, so they hold 0 after an overwrite run and their prior value after an accumulate run.
- Overflow: a signed accumulator add whose result leaves BUS_WIDTH range sets that element's flag. The flag stays set until a LOAD with mode=0 or reset.
- start_i while busy_o=1 or in DONE is ignored, with no queuing.
- Operand inputs may change freely after the start cycle; only captured copies are used.
- Reset at any time, including mid-RUN: FSM returns to IDLE, and all accumulators, flags and pipeline registers clear.

## Timing
- Reset values: busy_o=0, done_o=0, c_matrix_o=0, flags_o=0, FSM=IDLE.
- Call the edge that samples start_i edge 0.
  - busy_o is high from edge 0 until edge N+K+M.
  - done_o is high for the single cycle following edge N+K+M.
- Latency from start to done is N+K+M cycles; for 4×4×4 that is 12.
- c_matrix_o and flags_o are registered outputs. They are final and stable while done_o=1 and remain stable until the next accepted start.
- Intermediate values are visible during RUN and must be ignored.
- start_i high during the done_o cycle is ignored. The earliest accepted restart is the cycle after done_o.

## Configuration
- MATMUL_SAT_EN defined: an overflowing add clamps the accumulator to +2^(BUS_WIDTH−1)−1 or −2^(BUS_WIDTH−1), by the sign of the true result, and sets the flag.
- MATMUL_SAT_EN undefined: an overflowing add wraps (two's complement) and sets the flag.
- Flag behaviour is identical in both builds.

## Test plan
- Defaults, N=K=M=2 (fields=1), A=[[1,2],[3,4]], B=[[5,6],[7,8]], mode=0 -> C=[[19,22],[43,50]], all other elements 0, flags 0, done_o pulse 6 edges after start.
- Defaults, 4×4×4, all A=B=−128, mode=0 -> every C element 65536, no flags, done_o at edge 12. Repeat with mode=1 -> every element 131072.
- N=3, K=1, M=2, A column [1,−2,3], B row [4,5] -> C rows [4,5], [−8,−10], [12,15]; row 3 and column 2/3 elements stay 0.
- DATA_WIDTH=8, BUS_WIDTH=16, 2×2×2, all A=B=−128 -> all flags 1. With MATMUL_SAT_EN every C=32767; without it every C=−32768.
- Assert start_i again during RUN, then pull rst_ni low mid-RUN -> second start ignored; busy_o, done_o, c_matrix_o and flags_o all 0 immediately on reset. A fresh start after release runs normally.
